load_store_unit: RTL and testbench

Multi-cycle load/store unit between the core's execute stage and a handshaked data memory. It accepts one load or store request at a time, checks alignment and func3, and generates a word-aligned memory access with byte enables and lane-replicated store data. It waits for the memory response and returns sign- or zero-extended load data, with an error flag, as a single-cycle completion pulse. The core stalls on `req_ready` low.

---
 rtl/load_store_unit_pkg.sv | 42 ++++
 rtl/load_store_unit_load_extend.sv | 25 ++
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 tb/tb_load_store_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: data word, func3 encodings, FSM states
// and the request legality helpers used at accept time.
package load_store_unit_pkg;

  typedef logic [31:0] word;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } LOAD_FUNC3;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } STORE_FUNC3;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_ISSUE,
    LSU_WAIT,
    LSU_RESP
  } lsu_state_t;

  function automatic logic is_illegal_func3(input logic is_store, input logic [2:0] f3);
    if (is_store) return f3 > 3'b010;
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

  // func3[1:0] encodes the access size for both loads and stores
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Selects the addressed lane of a memory word and sign/zero-extends it
// according to the load func3.
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [2:0] func3,
  input  logic [1:0] byte_off,
  input  word        mem_rdata,
  output word        ext_data
);

  word lane;

  always_comb begin
    lane = mem_rdata >> {byte_off, 3'b000};
    case (func3)
      LB:      ext_data = {{24{lane[7]}}, lane[7:0]};
      LH:      ext_data = {{16{lane[15]}}, lane[15:0]};
      LBU:     ext_data = {24'h0, lane[7:0]};
      LHU:     ext_data = {16'h0, lane[15:0]};
      default: ext_data = lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: one request at a time, word-aligned memory
// handshake, response timeout and a single-cycle completion pulse.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int RSP_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(RSP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSP_TIMEOUT - 1);

  lsu_state_t       state_q, state_d;
  logic             is_store_q, is_store_d;
  logic [2:0]       func3_q, func3_d;
  word              addr_q, addr_d;
  word              wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  word              rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  word  ext_data;
  word  load_result;
  logic issuing;
  logic [3:0] be_calc;
  word  wdata_rep;

  load_extend u_load_extend (
    .func3    (func3_q),
    .byte_off (addr_q[1:0]),
    .mem_rdata(mem_rdata),
    .ext_data (ext_data)
  );

  assign load_result = is_store_q ? '0 : ext_data;

  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    func3_d     = func3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      LSU_IDLE: begin
        if (req_valid) begin
          is_store_d = req_is_store;
          func3_d    = req_func3;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          cnt_d      = '0;
          if (is_illegal_func3(req_is_store, req_func3) ||
              is_misaligned(req_func3, req_addr[1:0])) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = LSU_RESP;
          end else begin
            state_d = LSU_ISSUE;
          end
        end
      end
      LSU_ISSUE: begin
        cnt_d = cnt_q + CNT_W'(1);
        // a completion on the final counted cycle beats the timeout
        if (mem_gnt && mem_rvalid) begin
          rsp_rdata_d = load_result;
          rsp_err_d   = 1'b0;
          state_d     = LSU_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = LSU_RESP;
        end else if (mem_gnt) begin
          state_d = LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_rvalid) begin
          rsp_rdata_d = load_result;
          rsp_err_d   = 1'b0;
          state_d     = LSU_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = LSU_RESP;
        end
      end
      LSU_RESP: begin
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        state_d     = LSU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LSU_IDLE;
      is_store_q  <= 1'b0;
      func3_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      func3_q     <= func3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    case (func3_q[1:0])
      2'b00: begin
        be_calc   = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_calc   = 4'b0011 << addr_q[1:0];
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        be_calc   = 4'b1111;
        wdata_rep = wdata_q;
      end
    endcase
  end

  // memory-side outputs are derived from state so reset clears them immediately
  assign issuing   = (state_q == LSU_ISSUE);
  assign mem_req   = issuing;
  assign mem_we    = issuing & is_store_q;
  assign mem_addr  = issuing ? {addr_q[31:2], 2'b00} : '0;
  assign mem_be    = issuing ? be_calc : '0;
  assign mem_wdata = issuing ? wdata_rep : '0;

  assign req_ready = (state_q == LSU_IDLE);
  assign rsp_valid = (state_q == LSU_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard testbench for load_store_unit with a configurable memory responder.
module tb_load_store_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_store;
   logic [2:0]  req_func3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int checkCount = 0;
   int passCount = 0;
   int rspCount = 0;
   int pushCount = 0;
   logic [32:0] expQ[$];

   int          gntDelay = 0;
   bit          rvSameCycle = 0;
   bit          respEnable = 1;
   bit          injectStray = 0;
   logic [31:0] memData = 32'h0;
   bit          pendingRv = 0;
   int          reqCycles = 0;
   logic        prevRspValid = 1'b0;

   load_store_unit #(.RSP_TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
      .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata)
   );

   // Free-running clock, 10 time units per cycle
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single point of comparison: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
   endtask

   // Memory model: grants after gntDelay request cycles, answers same cycle or one later
   initial begin
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         mem_gnt = 1'b0;
         mem_rvalid = 1'b0;
         if (!rst_n) begin
            pendingRv = 0;
            reqCycles = 0;
         end else begin
            if (injectStray) begin
               mem_rvalid = 1'b1;
               mem_rdata = 32'hDEAD_BEEF;
               injectStray = 0;
            end
            if (pendingRv) begin
               mem_rvalid = 1'b1;
               mem_rdata = memData;
               pendingRv = 0;
            end
            if (mem_req) begin
               if (reqCycles == gntDelay) begin
                  mem_gnt = 1'b1;
                  reqCycles = 0;
                  if (respEnable) begin
                     if (rvSameCycle) begin
                        mem_rvalid = 1'b1;
                        mem_rdata = memData;
                     end else begin
                        pendingRv = 1;
                     end
                  end
               end else begin
                  reqCycles++;
               end
            end else begin
               reqCycles = 0;
            end
         end
      end
   end

   // Scoreboard consumer: every completion pops and compares one expectation
   always @(negedge clk) begin
      if (rst_n && rsp_valid) begin
         rspCount++;
         checkOutput("rsp_not_adjacent", {31'h0, prevRspValid}, 32'h0);
         if (expQ.size() == 0) begin
            checkOutput("unexpected_rsp", {31'h0, rsp_valid}, 32'h0);
         end else begin
            logic [32:0] exp;
            exp = expQ.pop_front();
            checkOutput("rsp_rdata", rsp_rdata, exp[31:0]);
            checkOutput("rsp_err", {31'h0, rsp_err}, {31'h0, exp[32]});
         end
      end
      prevRspValid = rst_n && rsp_valid;
   end

   // Drives one request, checks memory-side outputs each cycle and the completion latency
   task automatic applyStimulus(input logic isStore, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input bit expMemAccess, input logic [3:0] expBe,
                                input logic [31:0] expWdata, input logic [31:0] expRdata,
                                input logic expErr, input int expLatency);
      int  cyc;
      bit  done;
      bit  sawReq;
      checkOutput("ready_before_req", {31'h0, req_ready}, 32'h1);
      req_valid = 1'b1;
      req_is_store = isStore;
      req_func3 = f3;
      req_addr = addr;
      req_wdata = wdata;
      expQ.push_back({expErr, expRdata});
      pushCount++;
      @(negedge clk);
      req_valid = 1'b0;
      cyc = 1;
      done = 0;
      sawReq = 0;
      while (!done && cyc <= 40) begin
         if (!expMemAccess) checkOutput("no_mem_req", {31'h0, mem_req}, 32'h0);
         if (mem_req) begin
            sawReq = 1;
            checkOutput("mem_addr", mem_addr, {addr[31:2], 2'b00});
            checkOutput("mem_be", {28'h0, mem_be}, {28'h0, expBe});
            checkOutput("mem_we", {31'h0, mem_we}, {31'h0, isStore});
            if (isStore) checkOutput("mem_wdata", mem_wdata, expWdata);
         end
         if (rsp_valid) begin
            done = 1;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      if (!done) begin
         checkOutput("rsp_bound_expired", 32'h0, 32'h1);
      end else begin
         checkOutput("rsp_latency", cyc, expLatency);
         if (expMemAccess) checkOutput("saw_mem_req", {31'h0, sawReq}, 32'h1);
         @(negedge clk);
         checkOutput("rsp_single_pulse", {31'h0, rsp_valid}, 32'h0);
         checkOutput("ready_after_rsp", {31'h0, req_ready}, 32'h1);
      end
   endtask

   initial begin
      int accepts;
      int lastAccept;
      int cyc;
      int strayHits;
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_is_store = 1'b0;
      req_func3 = 3'b000;
      req_addr = 32'h0;
      req_wdata = 32'h0;
      #12;
      checkOutput("reset_req_ready", {31'h0, req_ready}, 32'h1);
      checkOutput("reset_mem_req", {31'h0, mem_req}, 32'h0);
      checkOutput("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      checkOutput("reset_mem_addr", mem_addr, 32'h0);
      checkOutput("reset_mem_be", {28'h0, mem_be}, 32'h0);
      checkOutput("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // SB with replicated data, gnt then rvalid one cycle later
      gntDelay = 0; rvSameCycle = 0; respEnable = 1; memData = 32'h1357_9BDF;
      applyStimulus(1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 1, 4'b1000, 32'hDDDD_DDDD, 32'h0, 1'b0, 3);

      // Lane extraction and extension at byte offset 2
      memData = 32'h12F0_3456;
      applyStimulus(1'b0, 3'b000, 32'h0000_2002, 32'h0, 1, 4'b0100, 32'h0, 32'hFFFF_FFF0, 1'b0, 3);
      applyStimulus(1'b0, 3'b100, 32'h0000_2002, 32'h0, 1, 4'b0100, 32'h0, 32'h0000_00F0, 1'b0, 3);
      applyStimulus(1'b0, 3'b001, 32'h0000_2002, 32'h0, 1, 4'b1100, 32'h0, 32'h0000_12F0, 1'b0, 3);
      memData = 32'h8001_7F00;
      applyStimulus(1'b0, 3'b001, 32'h0000_2000, 32'h0, 1, 4'b0011, 32'h0, 32'h0000_7F00, 1'b0, 3);
      applyStimulus(1'b0, 3'b101, 32'h0000_2002, 32'h0, 1, 4'b1100, 32'h0, 32'h0000_8001, 1'b0, 3);
      applyStimulus(1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 1, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0, 3);

      // gnt and rvalid together shorten the access by one cycle
      rvSameCycle = 1; memData = 32'hA5A5_0F0F;
      applyStimulus(1'b0, 3'b010, 32'h0000_2000, 32'h0, 1, 4'b1111, 32'h0, 32'hA5A5_0F0F, 1'b0, 2);
      applyStimulus(1'b1, 3'b010, 32'h0000_2004, 32'h0102_0304, 1, 4'b1111, 32'h0102_0304, 32'h0, 1'b0, 2);

      // Misaligned and illegal func3 complete with error and never touch memory
      applyStimulus(1'b0, 3'b010, 32'h0000_3001, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b1, 1);
      applyStimulus(1'b1, 3'b001, 32'h0000_3003, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b1, 1);
      applyStimulus(1'b0, 3'b011, 32'h0000_3000, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b1, 1);
      applyStimulus(1'b0, 3'b110, 32'h0000_3000, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b1, 1);
      applyStimulus(1'b1, 3'b011, 32'h0000_3000, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b1, 1);

      // Grant withheld for 5 cycles; request must hold steady
      rvSameCycle = 0; gntDelay = 5; memData = 32'h5555_AAAA;
      applyStimulus(1'b0, 3'b010, 32'h0000_5004, 32'h0, 1, 4'b1111, 32'h0, 32'h5555_AAAA, 1'b0, 8);

      // Completion exactly on the last allowed cycle beats the timeout
      rvSameCycle = 1; gntDelay = 7; memData = 32'h0BAD_F00D;
      applyStimulus(1'b0, 3'b010, 32'h0000_5008, 32'h0, 1, 4'b1111, 32'h0, 32'h0BAD_F00D, 1'b0, 9);

      // No response: error after 8 ISSUE/WAIT cycles
      rvSameCycle = 0; gntDelay = 0; respEnable = 0;
      applyStimulus(1'b0, 3'b010, 32'h0000_500C, 32'h0, 1, 4'b1111, 32'h0, 32'h0, 1'b1, 9);

      // Late stray response must not create a completion
      respEnable = 1;
      injectStray = 1;
      strayHits = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (rsp_valid) strayHits++;
      end
      checkOutput("stray_no_rsp", strayHits, 0);

      // Back-to-back with req_valid held high
      gntDelay = 0; rvSameCycle = 0; memData = 32'hCAFE_0001;
      req_valid = 1'b1; req_is_store = 1'b0; req_func3 = 3'b010; req_addr = 32'h0000_4000;
      accepts = 0; lastAccept = -1; cyc = 0;
      while (accepts < 3 && cyc < 40) begin
         if (req_ready) begin
            expQ.push_back({1'b0, memData});
            pushCount++;
            if (lastAccept >= 0) checkOutput("b2b_interval", cyc - lastAccept, 4);
            lastAccept = cyc;
            accepts++;
         end
         @(negedge clk);
         cyc++;
      end
      req_valid = 1'b0;
      checkOutput("b2b_accepts", accepts, 3);
      cyc = 0;
      while ((expQ.size() != 0 || !req_ready) && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("b2b_drained", expQ.size(), 0);

      // Reset mid-access (WAIT, then ISSUE) aborts without a completion
      for (int mode = 0; mode < 2; mode++) begin
         respEnable = 0;
         gntDelay = (mode == 0) ? 0 : 20;
         req_valid = 1'b1; req_is_store = 1'b0; req_func3 = 3'b010; req_addr = 32'h0000_6000;
         @(negedge clk);
         req_valid = 1'b0;
         @(negedge clk);
         checkOutput("pre_reset_busy", {31'h0, req_ready}, 32'h0);
         checkOutput("pre_reset_mem_req", {31'h0, mem_req}, (mode == 0) ? 32'h0 : 32'h1);
         #2 rst_n = 1'b0;
         #1;
         checkOutput("async_mem_req", {31'h0, mem_req}, 32'h0);
         checkOutput("async_rsp_valid", {31'h0, rsp_valid}, 32'h0);
         checkOutput("async_req_ready", {31'h0, req_ready}, 32'h1);
         @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
         respEnable = 1; gntDelay = 0; memData = 32'h7777_1234;
         applyStimulus(1'b0, 3'b010, 32'h0000_6000, 32'h0, 1, 4'b1111, 32'h0, 32'h7777_1234, 1'b0, 3);
      end

      repeat (3) @(negedge clk);
      checkOutput("queue_empty", expQ.size(), 0);
      checkOutput("rsp_count", rspCount, pushCount);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   // Global bound so the run can never hang
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

endmodule
